axi_stom_select_s2: RTL

- Per-master-port response-select generator for the 3-port (2 slaves + default slave) AXI interconnect.
- Tracks outstanding read and write transactions issued by one master.
- Produces the RSELECT/BSELECT vectors consumed directly by the slave-to-master R/B arbiter.
- Enforces the interconnect's single-target ordering rule by holding AR/AW issue when a new request would target a different slave than the in-flight ones.

---
 rtl/axi_stom_select_s2.sv | 117 +++++++++++
 1 files changed

// File: rtl/axi_stom_select_s2.sv
// Response-select generator for one master port: tracks outstanding AR/AW
// transactions, steers R/B arbitration and holds issue to a different slave.
module axi_stom_select_s2_trk #(
    parameter int NUM   = 2,
    parameter int W_CID = 4,
    parameter int W_MID = 4,
    parameter int MID   = 0,
    parameter int W_CNT = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic                              i_valid,
    input  logic                              i_ready,
    input  logic [NUM:0]                      i_sel,
    output logic                              o_hold,
    input  logic [(NUM+1)*(W_MID+W_CID)-1:0]  i_id,
    input  logic [NUM:0]                      i_svalid,
    input  logic [NUM:0]                      i_slast,
    input  logic                              i_mready,
    input  logic [NUM:0]                      i_grant,
    output logic [NUM:0]                      o_select,
    output logic                              o_err
);
    localparam int W_ID = W_MID + W_CID;

    logic [W_CNT-1:0] r_cnt;
    logic [NUM:0]     r_tgt;
    logic             r_err;

    logic w_issue, w_retire, w_max, w_zero;

    assign w_issue  = i_valid & i_ready;
    assign w_retire = (|(i_grant & i_svalid & i_slast)) & i_mready;
    assign w_max    = &r_cnt;
    assign w_zero   = (r_cnt == '0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt <= '0;
            r_tgt <= '0;
            r_err <= 1'b0;
        end else begin
            // Target follows the latest issue; cleared only when the last one drains.
            if (w_issue)
                r_tgt <= i_sel;
            else if (w_retire && r_cnt == W_CNT'(1))
                r_tgt <= '0;

            if (w_issue && !w_retire && !w_max)
                r_cnt <= r_cnt + 1'b1;
            else if (w_retire && !w_issue && !w_zero)
                r_cnt <= r_cnt - 1'b1;

            if ((w_retire && w_zero) || (w_issue && !w_retire && w_max))
                r_err <= 1'b1;
        end
    end

    assign o_hold = (!w_zero && (i_sel != r_tgt) && i_valid) || w_max;
    assign o_err  = r_err;

    for (genvar k = 0; k <= NUM; k++) begin : g_sel
        assign o_select[k] = i_svalid[k] & (i_id[k*W_ID+W_CID +: W_MID] == W_MID'(MID))
                             & r_tgt[k] & !w_zero;
    end
endmodule

module axi_stom_select_s2 #(
    parameter int NUM   = 2,
    parameter int W_CID = 4,
    parameter int W_MID = 4,
    parameter int MID   = 0,
    parameter int W_CNT = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic                              M_ARVALID,
    input  logic                              M_ARREADY,
    input  logic [NUM:0]                      ARSEL,
    output logic                              ARHOLD,
    input  logic [(NUM+1)*(W_MID+W_CID)-1:0]  S_RID,
    input  logic [NUM:0]                      S_RVALID,
    input  logic [NUM:0]                      S_RLAST,
    input  logic                              M_RREADY,
    input  logic [NUM:0]                      RGRANT,
    output logic [NUM:0]                      RSELECT,
    input  logic                              M_AWVALID,
    input  logic                              M_AWREADY,
    input  logic [NUM:0]                      AWSEL,
    output logic                              AWHOLD,
    input  logic [(NUM+1)*(W_MID+W_CID)-1:0]  S_BID,
    input  logic [NUM:0]                      S_BVALID,
    input  logic                              M_BREADY,
    input  logic [NUM:0]                      BGRANT,
    output logic [NUM:0]                      BSELECT,
    output logic                              RERR,
    output logic                              BERR
);
    axi_stom_select_s2_trk #(
        .NUM(NUM), .W_CID(W_CID), .W_MID(W_MID), .MID(MID), .W_CNT(W_CNT)
    ) u_rd (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .i_valid(M_ARVALID), .i_ready(M_ARREADY), .i_sel(ARSEL), .o_hold(ARHOLD),
        .i_id(S_RID), .i_svalid(S_RVALID), .i_slast(S_RLAST), .i_mready(M_RREADY),
        .i_grant(RGRANT), .o_select(RSELECT), .o_err(RERR)
    );

    // B channel has single-beat responses, so every granted beat is a last beat.
    axi_stom_select_s2_trk #(
        .NUM(NUM), .W_CID(W_CID), .W_MID(W_MID), .MID(MID), .W_CNT(W_CNT)
    ) u_wr (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .i_valid(M_AWVALID), .i_ready(M_AWREADY), .i_sel(AWSEL), .o_hold(AWHOLD),
        .i_id(S_BID), .i_svalid(S_BVALID), .i_slast({(NUM+1){1'b1}}), .i_mready(M_BREADY),
        .i_grant(BGRANT), .o_select(BSELECT), .o_err(BERR)
    );
endmodule
